// File: rtl/lc3_pkg.sv
// Shared LC-3 control encodings: FSM states, opcodes and datapath mux selects.
package lc3_pkg;

  typedef enum logic [4:0] {
    HALTED, S_18, S_33, S_35, S_32,
    S_01, S_05, S_09, S_00, S_22, S_12, S_04, S_21,
    S_06, S_07, S_25, S_27, S_23, S_16,
    P1, P2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PC_PLUS1 = 2'b00;
  localparam logic [1:0] PC_BUS   = 2'b01;
  localparam logic [1:0] PC_ADDR  = 2'b10;

  localparam logic [1:0] A2_ZERO   = 2'b00;
  localparam logic [1:0] A2_SEXT5  = 2'b01;
  localparam logic [1:0] A2_SEXT8  = 2'b10;
  localparam logic [1:0] A2_SEXT10 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_NOT   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

  // States that hold on the SRAM for MEM_WAIT cycles.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/isdu_mem_timer.sv
// SRAM access timer: counts cycles spent in a memory state, flags the last one.
module isdu_mem_timer #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic done
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wait_cnt <= '0;
    else if (start)         wait_cnt <= '0;
    else if (en && !done)   wait_cnt <= wait_cnt + CW'(1);
  end

  assign done = (wait_cnt == CW'(MEM_WAIT - 1));

endmodule

// File: rtl/isdu.sv
// LC-3 control FSM: sequences fetch/decode/execute and drives all datapath
// loads, bus gates, mux selects and SRAM strobes as a Moore decode of state.
module isdu
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t state, next_state;
  logic   mem_done, mem_start;

  // Timer restarts on every entry into a memory state; memory states are never adjacent.
  assign mem_start = is_mem_state(next_state) && !is_mem_state(state);

  isdu_mem_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .clk   (Clk),
    .rst   (Reset),
    .start (mem_start),
    .en    (is_mem_state(state)),
    .done  (mem_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= HALTED;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      HALTED: if (Run) next_state = S_18;
      S_18:   next_state = S_33;
      S_33:   if (mem_done) next_state = S_35;
      S_35:   next_state = S_32;
      S_32: begin
        case (Opcode)
          OP_ADD:   next_state = S_01;
          OP_AND:   next_state = S_05;
          OP_NOT:   next_state = S_09;
          OP_BR:    next_state = S_00;
          OP_JMP:   next_state = S_12;
          OP_JSR:   next_state = S_04;
          OP_LDR:   next_state = S_06;
          OP_STR:   next_state = S_07;
          OP_PAUSE: next_state = P1;
          default:  next_state = S_18;
        endcase
      end
      S_01, S_05, S_09: next_state = S_18;
      S_00:   next_state = BEN ? S_22 : S_18;
      S_22, S_12, S_21, S_27: next_state = S_18;
      S_04:   next_state = S_21;
      S_06:   next_state = S_25;
      S_07:   next_state = S_23;
      S_25:   if (mem_done) next_state = S_27;
      S_23:   next_state = S_16;
      S_16:   if (mem_done) next_state = S_18;
      P1:     if (Continue) next_state = P2;
      P2:     if (!Continue) next_state = S_18;
      default: next_state = HALTED;
    endcase
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PC_PLUS1; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = A2_ZERO; ALUK = ALU_ADD;
    MIO_EN = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b1;
    unique case (state)
      S_18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PC_PLUS1; end
      S_33, S_25: begin
        Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = mem_done;
      end
      S_35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_32: LD_BEN = 1'b1;
      S_01, S_05, S_09: begin
        SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK = (state == S_01) ? ALU_ADD : (state == S_05) ? ALU_AND : ALU_NOT;
        // Immediate vs register operand only matters for ADD/AND.
        SR2MUX = (state == S_09) ? 1'b0 : IR_5;
      end
      S_22: begin PCMUX = PC_ADDR; ADDR2MUX = A2_SEXT8; LD_PC = 1'b1; end
      S_12: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_ZERO; PCMUX = PC_ADDR; LD_PC = 1'b1;
      end
      S_04: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S_21: begin PCMUX = PC_ADDR; ADDR2MUX = A2_SEXT10; LD_PC = 1'b1; end
      S_06, S_07: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_SEXT5; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_23: begin ALUK = ALU_PASSA; GateALU = 1'b1; LD_MDR = 1'b1; end
      S_16: Mem_WE = 1'b0;
      P1:   LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu.sv
// Directed bench for the isdu control FSM: walks each supported instruction.
module tb_isdu;
  import lc3_pkg::*;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mio_en, mem_oe, mem_we;
  } o_t;

  logic Clk = 1'b0, Reset = 1'b1, Run = 1'b0, Continue = 1'b0;
  logic [3:0] Opcode = 4'b0000;
  logic IR_5 = 1'b0, BEN = 1'b0;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;
  o_t obs, e;
  int ncmp = 0, nerr = 0;

  always #5 Clk = ~Clk;

  isdu #(.MEM_WAIT(2)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
    .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_OE, Mem_WE};

  function automatic o_t dflt();
    o_t d = '0;
    d.mem_oe = 1'b1;
    d.mem_we = 1'b1;
    return d;
  endfunction

  task automatic chk(input string tag, input state_t es, input o_t eo);
    ncmp++;
    assert (dut.state === es) else begin
      nerr++;
      $error("FAIL %s state: got %0d want %0d", tag, dut.state, es);
    end
    ncmp++;
    assert (obs === eo) else begin
      nerr++;
      $error("FAIL %s outs: got %h want %h", tag, obs, eo);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // From S_18 (already checked): walks S_33 x2, S_35 and lands in S_32.
  task automatic fetch(input string tag);
    o_t x;
    tick(); x = dflt(); x.mem_oe = 1'b0; x.mio_en = 1'b1;
    chk({tag, ".s33a"}, S_33, x);
    tick(); x.ld_mdr = 1'b1;
    chk({tag, ".s33b"}, S_33, x);
    tick(); x = dflt(); x.gate_mdr = 1'b1; x.ld_ir = 1'b1;
    chk({tag, ".s35"}, S_35, x);
    tick(); x = dflt(); x.ld_ben = 1'b1;
    chk({tag, ".s32"}, S_32, x);
  endtask

  o_t e18;

  initial begin
    e18 = dflt(); e18.gate_pc = 1'b1; e18.ld_mar = 1'b1; e18.ld_pc = 1'b1;

    #2 chk("reset", HALTED, dflt());
    @(negedge Clk) Reset = 1'b0;
    tick(); chk("halt_idle", HALTED, dflt());
    Run = 1'b1;
    tick(); chk("run_s18", S_18, e18);
    Run = 1'b0;

    // ADD with immediate
    Opcode = OP_ADD; IR_5 = 1'b1;
    fetch("add");
    tick(); e = dflt(); e.sr1mux = 1'b1; e.sr2mux = 1'b1; e.aluk = ALU_ADD;
    e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
    chk("add_s01", S_01, e);
    tick(); chk("add_s18", S_18, e18);

    // AND register form
    Opcode = OP_AND; IR_5 = 1'b0;
    fetch("and");
    tick(); e = dflt(); e.sr1mux = 1'b1; e.aluk = ALU_AND;
    e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
    chk("and_s05", S_05, e);
    tick(); chk("and_s18", S_18, e18);

    // BR not taken
    Opcode = OP_BR; BEN = 1'b0;
    fetch("brn");
    tick(); chk("brn_s00", S_00, dflt());
    tick(); chk("brn_s18", S_18, e18);

    // BR taken
    BEN = 1'b1;
    fetch("brt");
    tick(); chk("brt_s00", S_00, dflt());
    tick(); e = dflt(); e.pcmux = PC_ADDR; e.addr2mux = A2_SEXT8; e.ld_pc = 1'b1;
    chk("brt_s22", S_22, e);
    tick(); chk("brt_s18", S_18, e18);
    BEN = 1'b0;

    // STR
    Opcode = OP_STR;
    fetch("str");
    tick(); e = dflt(); e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.addr2mux = A2_SEXT5;
    e.gate_marmux = 1'b1; e.ld_mar = 1'b1;
    chk("str_s07", S_07, e);
    tick(); e = dflt(); e.aluk = ALU_PASSA; e.gate_alu = 1'b1; e.ld_mdr = 1'b1;
    chk("str_s23", S_23, e);
    tick(); e = dflt(); e.mem_we = 1'b0;
    chk("str_s16a", S_16, e);
    tick(); chk("str_s16b", S_16, e);
    tick(); chk("str_s18", S_18, e18);

    // LDR
    Opcode = OP_LDR;
    fetch("ldr");
    tick(); e = dflt(); e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.addr2mux = A2_SEXT5;
    e.gate_marmux = 1'b1; e.ld_mar = 1'b1;
    chk("ldr_s06", S_06, e);
    tick(); e = dflt(); e.mem_oe = 1'b0; e.mio_en = 1'b1;
    chk("ldr_s25a", S_25, e);
    tick(); e.ld_mdr = 1'b1;
    chk("ldr_s25b", S_25, e);
    tick(); e = dflt(); e.gate_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
    chk("ldr_s27", S_27, e);
    tick(); chk("ldr_s18", S_18, e18);

    // PAUSE with 3-cycle Continue pulse; Run is ignored while paused
    Opcode = OP_PAUSE;
    fetch("pau");
    tick(); e = dflt(); e.ld_led = 1'b1;
    chk("pau_p1a", P1, e);
    Run = 1'b1;
    tick(); chk("pau_p1b", P1, e);
    Run = 1'b0; Continue = 1'b1;
    tick(); chk("pau_p2a", P2, dflt());
    tick(); chk("pau_p2b", P2, dflt());
    tick(); chk("pau_p2c", P2, dflt());
    Continue = 1'b0;
    tick(); chk("pau_s18", S_18, e18);

    // JSR: R7 written before PC load
    Opcode = OP_JSR;
    fetch("jsr");
    tick(); e = dflt(); e.gate_pc = 1'b1; e.drmux = 1'b1; e.ld_reg = 1'b1;
    chk("jsr_s04", S_04, e);
    tick(); e = dflt(); e.pcmux = PC_ADDR; e.addr2mux = A2_SEXT10; e.ld_pc = 1'b1;
    chk("jsr_s21", S_21, e);
    tick(); chk("jsr_s18", S_18, e18);

    // JMP
    Opcode = OP_JMP;
    fetch("jmp");
    tick(); e = dflt(); e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.pcmux = PC_ADDR; e.ld_pc = 1'b1;
    chk("jmp_s12", S_12, e);
    tick(); chk("jmp_s18", S_18, e18);

    // Unsupported opcode behaves as NOP
    Opcode = 4'b1111;
    fetch("nop");
    tick(); chk("nop_s18", S_18, e18);

    // Async reset in the middle of S_33, then restart
    tick(); e = dflt(); e.mem_oe = 1'b0; e.mio_en = 1'b1;
    chk("rst_s33", S_33, e);
    #2 Reset = 1'b1;
    #1 chk("rst_mid", HALTED, dflt());
    @(negedge Clk) Reset = 1'b0; Run = 1'b1;
    tick(); chk("rst_run", S_18, e18);
    Run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
